counter_updown_mod: RTL
=======================

# counter_updown_mod

Parametrised up/down modulo counter with synchronous load, count enable, terminal-count and wrap indication. It replaces the fixed 8-bit load counter as the general-purpose counting primitive for timers, dividers and address generators in the chapter_6 designs. An optional saturating mode is selectable at compile time.

## Interface

- WIDTH, 8, counter width in bits; WIDTH >= 2
- MOD, 256, count modulus; count range 0..MOD-1; 2 <= MOD <= 2**WIDTH (elaboration error otherwise)

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe
- data_load  input  WIDTH  load value
- sat  input  1  saturate instead of wrap (present only with COUNTER_SAT_EN)
- cnt  output  WIDTH  current count, registered
- tc  output  1  terminal count, combinational: en & (cnt == term), term = MOD-1 if up else 0
- wrap  output  1  registered one-cycle pulse, high in the cycle after cnt wrapped

## Operation

- Per-edge priority: rst low > load > en > hold.
- rst low at edge: cnt <= 0, wrap <= 0. Asserting rst mid-count discards state; first count after release starts from 0.
- load high: cnt <= data_load if data_load < MOD, else cnt <= MOD-1 (clamp). wrap <= 0. en and up ignored that cycle.
- en high, no load:
  - up = 1: cnt <= cnt+1; if cnt == MOD-1 then cnt <= 0, wrap <= 1.
  - up = 0: cnt <= cnt-1; if cnt == 0 then cnt <= MOD-1, wrap <= 1.
- en low, no load: cnt holds, wrap <= 0.
- wrap is 0 on every edge that is not a wrap event; back-to-back wraps (MOD = 2) give wrap high on consecutive cycles.
- Direction may change on any cycle; it takes effect at that edge, no pipeline.
- Arithmetic done at WIDTH+1 bits internally; no carry is exposed. For MOD = 2**WIDTH, wrap compare reduces to natural overflow.

## Timing

- Reset values: cnt = 0, wrap = 0; tc = en & ~up during reset (cnt = 0 is terminal when counting down).
- Load/count latency: 1 cycle, visible on cnt after the edge.
- tc has zero latency from en/up/cnt; wrap lags the wrap edge by 0 cycles relative to cnt (both update at the same edge).

## Configuration

- COUNTER_SAT_EN defined: sat port exists. sat = 1 with en at terminal: cnt holds at term, wrap stays 0, tc stays high. sat = 0: wrap behaviour as above. sat may change any cycle.
- COUNTER_SAT_EN undefined: no sat port, no saturation logic; always wrap.

## Structure

- Package counter_pkg: function to compute term from MOD and direction, clamp function for load value, localparam MAX_VAL = MOD-1 helper.
- No sub-module; single module, next-state block plus register block.

## Test plan

- Reset: rst = 0 for 2 edges with en = 1, up = 1 -> cnt = 0, wrap = 0; release, 3 edges -> cnt = 3.
- Up wrap, WIDTH = 4, MOD = 10: count from 0, 10 edges -> cnt 1..9 then 0, wrap high exactly once with cnt = 0, tc high when cnt = 9.
- Down wrap, MOD = 10: load 1, down 2 edges -> cnt 0 then 9, wrap pulse on the 9; tc high at cnt = 0.
- Load priority/clamp: load = 1, en = 1, data_load = 12, MOD = 10 -> cnt = 9, no increment; data_load = 5 -> cnt = 5.
- Hold and mid-count reset: en = 0 for 5 edges -> cnt unchanged; rst = 0 at cnt = 7 -> cnt = 0 next edge.
- COUNTER_SAT_EN, sat = 1, MOD = 10, up from 8 -> cnt 9, 9, 9, wrap never high; flip up = 0 -> 8.

Source files
------------

// File: rtl/counter_pkg.sv
// Helpers for counter_updown_mod: terminal value, load clamp and maximum count.
package counter_pkg;

  function automatic int unsigned max_val(input int unsigned mod);
    return mod - 1;
  endfunction

  // Terminal count is the last value before a wrap in the current direction.
  function automatic int unsigned term_value(input int unsigned mod, input logic up);
    return up ? max_val(mod) : 0;
  endfunction

  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned mod);
    return (val < mod) ? val : max_val(mod);
  endfunction

endpackage

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with synchronous load, terminal count and wrap pulse.
// Define COUNTER_SAT_EN to add the sat port (saturate at terminal instead of wrapping).
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MOD   = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] data_load,
`ifdef COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || MOD < 2 || 64'(MOD) > (64'(1) << WIDTH)) begin : g_bad_param
    $error("counter_updown_mod: need WIDTH >= 2 and 2 <= MOD <= 2**WIDTH");
  end

  localparam int unsigned      MAX_VAL = max_val(MOD);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] term;
  logic             at_term;
  logic             sat_hold;

  assign term    = WIDTH'(term_value(MOD, up));
  assign at_term = (cnt_q == term);

`ifdef COUNTER_SAT_EN
  assign sat_hold = sat & at_term;
`else
  assign sat_hold = 1'b0;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = WIDTH'(clamp_load(32'(data_load), MOD));
    end else if (en && !sat_hold) begin
      // Explicit terminal compare also covers MOD = 2**WIDTH, where it matches natural overflow.
      if (at_term) begin
        cnt_d  = up ? '0 : WIDTH'(MAX_VAL);
        wrap_d = 1'b1;
      end else if (up) begin
        cnt_d = WIDTH'({1'b0, cnt_q} + ONE_EXT);
      end else begin
        cnt_d = WIDTH'({1'b0, cnt_q} - ONE_EXT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign tc   = en & at_term;

endmodule
